pn_checker: RTL

PN_CHECKER -- requirements
Module: pn_checker

---
 rtl/pn_checker_pkg.sv | 14 +
 rtl/prbs7_lfsr.sv | 36 +++
 rtl/pn_checker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pn_checker_pkg.sv
// Shared constants and types for the PRBS-7 pattern checker.
package pn_checker_pkg;

  localparam int PRBS7_W = 7;
  localparam int TAP_HI  = 6;
  localparam int TAP_LO  = 5;
  localparam int CNT_W   = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS-7 (x^7+x^6+1) shift register: loads received bits while searching,
// free-runs on its own prediction (flywheel) once locked.
module prbs7_lfsr
  import pn_checker_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic load_i,
  input  logic data_i,
  output logic pred_o,
  output logic zero_o
);

  logic [PRBS7_W-1:0] sr_q;
  logic [PRBS7_W-1:0] sr_d;

  assign pred_o = sr_q[TAP_HI] ^ sr_q[TAP_LO];
  assign zero_o = (sr_q == '0);

  always_comb begin
    sr_d = sr_q;
    if (en_i) begin
      sr_d = {sr_q[PRBS7_W-2:0], (load_i ? data_i : pred_o)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/pn_checker.sv
// PRBS-7 checker: search/lock FSM, windowed loss-of-lock detection, error pulse.
// Define PN_CHECKER_STATS_EN to build the bit_cnt/err_cnt statistics counters.
module pn_checker
  import pn_checker_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int EW = $clog2(LOSS_THR + 1);

  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WIN - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(LOSS_THR);

  state_e        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d, werr_inc;
  logic          pulse_q, pulse_d;
  logic          pred, sr_zero, bit_err;

  assign bit_err  = data_in ^ pred;
  assign werr_inc = werr_q + EW'(bit_err);

  prbs7_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .load_i (state_q == SEARCH),
    .data_i (data_in),
    .pred_o (pred),
    .zero_o (sr_zero)
  );

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    pulse_d = 1'b0;
    if (en) begin
      case (state_q)
        SEARCH: begin
          // An all-zero register predicts zero forever, so it never counts as a match.
          if (!bit_err && !sr_zero) begin
            if (match_q == MATCH_MAX - 1'b1) begin
              state_d = LOCKED;
              match_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          pulse_d = bit_err;
          // Threshold test precedes the wrap so a last-bit error still counts.
          if (werr_inc == ERR_MAX) begin
            state_d = SEARCH;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = pulse_q;

`ifdef PN_CHECKER_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (en) begin
      if (clr) begin
        bit_cnt_d = '0;
        err_cnt_d = '0;
      end else if (state_q == LOCKED) begin
        bit_cnt_d = sat_inc(bit_cnt_q);
        if (bit_err) begin
          err_cnt_d = sat_inc(err_cnt_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign bit_cnt    = '0;
  assign err_cnt    = '0;
`endif

endmodule
